// File: rtl/hazard_forward_scoreboard_pkg.sv
// rtl/hazard_forward_scoreboard_pkg.sv - shared tag layout and select-width helpers
// Tag word layout is {rd, load, wr}; FWD_RF is the "no forward" select value.
package hazard_forward_scoreboard_pkg;

  localparam int FWD_RF       = 0;
  localparam int TAG_WR_BIT   = 0;
  localparam int TAG_LOAD_BIT = 1;
  localparam int TAG_RD_LSB   = 2;

  function automatic int tag_width(input int ra_w);
    return ra_w + 2;
  endfunction

  function automatic int sel_width(input int n_stg);
    return (n_stg <= 1) ? 1 : $clog2(n_stg);
  endfunction

endpackage

// File: rtl/hazard_forward_scoreboard_src_match.sv
// rtl/hazard_forward_scoreboard_src_match.sv - youngest-match finder for one source operand
// Scans the forwardable tag stages and reports the youngest writer of src_addr.
module hazard_forward_scoreboard_src_match
  import hazard_forward_scoreboard_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int N_STG = 3,
  localparam int TAG_W = tag_width(RA_W),
  localparam int SEL_W = sel_width(N_STG)
) (
  input  logic [RA_W-1:0]              src_addr,
  input  logic                         src_used,
  input  logic [(N_STG-1)*TAG_W-1:0]   tags,
  output logic                         hit,
  output logic [SEL_W-1:0]             stage,
  output logic                         is_load
);

  // Walk oldest to youngest so the youngest writer overrides any older one.
  always_comb begin
    hit     = 1'b0;
    stage   = '0;
    is_load = 1'b0;
    if (src_used && src_addr != '0) begin
      for (int k = N_STG - 2; k >= 0; k--) begin
        if (tags[k*TAG_W + TAG_WR_BIT] &&
            tags[k*TAG_W + TAG_RD_LSB +: RA_W] == src_addr) begin
          hit     = 1'b1;
          stage   = SEL_W'(k);
          is_load = tags[k*TAG_W + TAG_LOAD_BIT];
        end
      end
    end
  end

endmodule

// File: rtl/hazard_forward_scoreboard.sv
// rtl/hazard_forward_scoreboard.sv - in-flight destination tag pipeline with registered forward selects
// Generates per-source EX forward selects, the load-use stall and a saturating stall counter.
module hazard_forward_scoreboard
  import hazard_forward_scoreboard_pkg::*;
#(
  parameter int RA_W       = 5,
  parameter int NUM_SRC    = 2,
  parameter int N_STG      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = sel_width(N_STG)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [NUM_SRC*RA_W-1:0]   id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [RA_W-1:0]           id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_memread,
  input  logic                      ex_flush,
  output logic                      stall,
  output logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel,
  output logic [CNT_W-1:0]          stall_count
);

  localparam int TAG_W = tag_width(RA_W);
  // The WB-stage tag is not held: that instruction writes the regfile before
  // the read, so it can never win a match and has no observable effect.
  localparam int HELD  = N_STG - 1;

  logic [HELD*TAG_W-1:0]     tags;
  logic [NUM_SRC-1:0]        hit;
  logic [NUM_SRC-1:0]        is_load;
  logic [NUM_SRC-1:0]        load_use;
  logic [NUM_SRC*SEL_W-1:0]  stage;
  logic [TAG_W-1:0]          id_tag;
  logic                      issue;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_forward_scoreboard_src_match #(
      .RA_W  (RA_W),
      .N_STG (N_STG)
    ) u_match (
      .src_addr (id_src_addr[i*RA_W +: RA_W]),
      .src_used (id_src_used[i]),
      .tags     (tags),
      .hit      (hit[i]),
      .stage    (stage[i*SEL_W +: SEL_W]),
      .is_load  (is_load[i])
    );

    // Load data is not yet available if the producer sits before LOAD_STAGE.
    assign load_use[i] = hit[i] && is_load[i] &&
                         (int'(stage[i*SEL_W +: SEL_W]) + 1 < LOAD_STAGE);
  end

  assign stall = id_valid && !ex_flush && (|load_use);
  assign issue = id_valid && !stall && !ex_flush;

  always_comb begin
    id_tag                        = '0;
    id_tag[TAG_WR_BIT]            = id_regwrite && (id_rd != '0);
    id_tag[TAG_LOAD_BIT]          = id_memread;
    id_tag[TAG_RD_LSB +: RA_W]    = id_rd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tags        <= '0;
      ex_fwd_sel  <= '0;
      stall_count <= '0;
    end else begin
      tags[0 +: TAG_W] <= issue ? id_tag : '0;
      // A flush squashes the instruction leaving EX as well as the one in ID.
      for (int k = 1; k < HELD; k++) begin
        tags[k*TAG_W +: TAG_W] <= (k == 1 && ex_flush) ? '0 : tags[(k-1)*TAG_W +: TAG_W];
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        ex_fwd_sel[i*SEL_W +: SEL_W] <= (issue && hit[i]) ?
            stage[i*SEL_W +: SEL_W] + SEL_W'(1) : SEL_W'(FWD_RF);
      end
      if (stall && stall_count != '1) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_scoreboard.sv
// tb/tb_hazard_forward_scoreboard.sv - directed and random bench against a cycle-history model
// The model keeps a log of what entered EX each cycle and answers hazards by looking back in it.
module tb_hazard_forward_scoreboard;

  localparam int RA_W       = 5;
  localparam int NUM_SRC    = 2;
  localparam int N_STG      = 3;
  localparam int LOAD_STAGE = 2;
  localparam int CNT_W      = 16;
  localparam int SMALL_CW   = 3;
  localparam int SEL_W      = $clog2(N_STG);
  localparam int LOG_N      = 4096;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      id_valid;
  logic [NUM_SRC*RA_W-1:0]   id_src_addr;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [RA_W-1:0]           id_rd;
  logic                      id_regwrite;
  logic                      id_memread;
  logic                      ex_flush;
  logic                      stall, stall_s;
  logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel, ex_fwd_sel_s;
  logic [CNT_W-1:0]          stall_count;
  logic [SMALL_CW-1:0]       stall_count_s;

  always #5 clk = ~clk;

  hazard_forward_scoreboard #(
    .RA_W(RA_W), .NUM_SRC(NUM_SRC), .N_STG(N_STG), .LOAD_STAGE(LOAD_STAGE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .ex_flush(ex_flush), .stall(stall),
    .ex_fwd_sel(ex_fwd_sel), .stall_count(stall_count)
  );

  hazard_forward_scoreboard #(
    .RA_W(RA_W), .NUM_SRC(NUM_SRC), .N_STG(N_STG), .LOAD_STAGE(LOAD_STAGE), .CNT_W(SMALL_CW)
  ) dut_small (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .ex_flush(ex_flush), .stall(stall_s),
    .ex_fwd_sel(ex_fwd_sel_s), .stall_count(stall_count_s)
  );

  typedef struct {
    bit valid;
    bit rw;
    int rd;
    bit load;
  } ent_t;

  ent_t ex_log[LOG_N];
  int   cyc;
  int   reset_floor;
  int   m_count;
  int   m_sel[NUM_SRC];
  bit   last_stall;
  bit   m_last_stall;
  int   vectors;
  int   miscompares;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sel_of(input int i);
    return int'(ex_fwd_sel[i*SEL_W +: SEL_W]);
  endfunction

  function automatic int sel_small_of(input int i);
    return int'(ex_fwd_sel_s[i*SEL_W +: SEL_W]);
  endfunction

  function automatic bit live(input int idx);
    return idx > reset_floor && ex_log[idx].valid;
  endfunction

  // One clock cycle: drive ID, predict from the EX-entry history, compare before and after the edge.
  task automatic apply(input bit v, input int a0, input int a1, input bit [1:0] used,
                       input int rd, input bit rw, input bit mr, input bit fl, input bit rst);
    int win[NUM_SRC];
    int addr;
    int idx;
    bit exp_stall;
    reset       = rst;
    id_valid    = v;
    id_src_addr = {RA_W'(a1), RA_W'(a0)};
    id_src_used = used;
    id_rd       = RA_W'(rd);
    id_regwrite = rw;
    id_memread  = mr;
    ex_flush    = fl;
    #1;
    exp_stall = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      addr   = (i == 0) ? a0 : a1;
      win[i] = -1;
      if (used[i] && addr != 0) begin
        for (int k = 0; k <= N_STG - 2; k++) begin
          idx = cyc - k;
          if (win[i] < 0 && live(idx) && ex_log[idx].rw && ex_log[idx].rd != 0 &&
              ex_log[idx].rd == addr)
            win[i] = k;
        end
      end
      if (win[i] >= 0 && ex_log[cyc - win[i]].load && (win[i] + 1) < LOAD_STAGE)
        exp_stall = 1'b1;
    end
    exp_stall = exp_stall && v && !fl;
    last_stall   = stall;
    m_last_stall = exp_stall;
    check("stall", stall, exp_stall);
    check("stall_small", stall_s, exp_stall);

    if (rst) begin
      m_count     = 0;
      reset_floor = cyc + 1;
      for (int i = 0; i < NUM_SRC; i++) m_sel[i] = 0;
    end else begin
      if (exp_stall) m_count++;
      for (int i = 0; i < NUM_SRC; i++)
        m_sel[i] = (exp_stall || fl || !v || win[i] < 0) ? 0 : win[i] + 1;
      if (fl) ex_log[cyc].valid = 1'b0;
    end
    ex_log[cyc + 1] = '{valid: v && !exp_stall && !fl && !rst, rw: rw, rd: rd, load: mr};

    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NUM_SRC; i++) begin
      check($sformatf("fwd_sel[%0d]", i), sel_of(i), m_sel[i]);
      check($sformatf("fwd_sel_small[%0d]", i), sel_small_of(i), m_sel[i]);
    end
    check("stall_count", stall_count, (m_count > 65535) ? 65535 : m_count);
    check("stall_count_small", stall_count_s, (m_count > 7) ? 7 : m_count);
  endtask

  task automatic issue_wr(input int rd, input bit load);
    apply(1'b1, 0, 0, 2'b00, rd, 1'b1, load, 1'b0, 1'b0);
  endtask

  task automatic bubble();
    apply(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic use_src(input int a0, input int a1, input bit [1:0] used);
    apply(1'b1, a0, a1, used, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    repeat (3) bubble();
  endtask

  initial begin
    bit       r_v, r_rw, r_mr, r_fl, r_rst;
    bit [1:0] r_used;
    int       r_a0, r_a1, r_rd;

    for (int j = 0; j < LOG_N; j++) ex_log[j] = '{valid: 0, rw: 0, rd: 0, load: 0};
    vectors = 0; miscompares = 0; cyc = 0; reset_floor = 0; m_count = 0;
    for (int i = 0; i < NUM_SRC; i++) m_sel[i] = 0;
    reset = 1'b1; id_valid = 1'b0; id_src_addr = '0; id_src_used = '0;
    id_rd = '0; id_regwrite = 1'b0; id_memread = 1'b0; ex_flush = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_sel0", sel_of(0), 0);
    check("rst_sel1", sel_of(1), 0);
    check("rst_count", stall_count, 0);
    check("rst_count_small", stall_count_s, 0);

    // Distance-based forwarding: EX, MEM, then out of range.
    issue_wr(3, 1'b0); use_src(3, 0, 2'b01);
    check("fwd_from_ex", sel_of(0), 1);
    drain();
    issue_wr(3, 1'b0); bubble(); use_src(3, 0, 2'b01);
    check("fwd_from_mem", sel_of(0), 2);
    drain();
    issue_wr(3, 1'b0); bubble(); bubble(); use_src(3, 0, 2'b01);
    check("fwd_from_wb", sel_of(0), 0);

    // Youngest writer wins; unrelated source stays on regfile.
    drain();
    issue_wr(3, 1'b0); issue_wr(3, 1'b0); use_src(4, 3, 2'b11);
    check("youngest_src1", sel_of(1), 1);
    check("other_src0", sel_of(0), 0);

    // Load-use: one stall, then forward from MEM.
    drain();
    issue_wr(5, 1'b1); use_src(5, 0, 2'b01);
    check("lu_stall", last_stall, 1);
    check("lu_count", stall_count, 1);
    use_src(5, 0, 2'b01);
    check("lu_release", last_stall, 0);
    check("lu_fwd_mem", sel_of(0), 2);

    // r0 never forwards; unused sources never stall.
    drain();
    issue_wr(0, 1'b1); use_src(0, 0, 2'b01);
    check("r0_sel", sel_of(0), 0);
    check("r0_stall", last_stall, 0);
    drain();
    issue_wr(5, 1'b1); use_src(5, 5, 2'b00);
    check("unused_stall", last_stall, 0);

    // Flush beats stall; reset drops a stall in progress.
    drain();
    issue_wr(5, 1'b1);
    apply(1'b1, 5, 0, 2'b01, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("flush_stall", last_stall, 0);
    check("flush_sel", sel_of(0), 0);
    drain();
    issue_wr(5, 1'b1);
    apply(1'b1, 5, 0, 2'b01, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("pre_reset_stall", last_stall, 1);
    use_src(5, 0, 2'b01);
    check("post_reset_stall", last_stall, 0);
    check("post_reset_count", stall_count, 0);

    // Nine load-use pairs saturate the 3-bit counter.
    for (int p = 0; p < 9; p++) begin
      issue_wr(5, 1'b1); use_src(5, 0, 2'b01); use_src(5, 0, 2'b01);
    end
    check("sat_small", stall_count_s, 7);
    check("count_nine", stall_count, 9);

    // Random traffic; ID is held while the model expects a stall.
    r_v = 0; r_rw = 0; r_mr = 0; r_used = 0; r_a0 = 0; r_a1 = 0; r_rd = 0;
    m_last_stall = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (!m_last_stall) begin
        r_v    = ($urandom_range(0, 99) < 85);
        r_a0   = $urandom_range(0, 5);
        r_a1   = $urandom_range(0, 5);
        r_used = 2'($urandom_range(0, 3));
        r_rd   = $urandom_range(0, 5);
        r_rw   = ($urandom_range(0, 99) < 70);
        r_mr   = ($urandom_range(0, 99) < 30);
      end
      r_fl  = ($urandom_range(0, 99) < 8);
      r_rst = ($urandom_range(0, 199) == 0);
      apply(r_v, r_a0, r_a1, r_used, r_rd, r_rw, r_mr, r_fl, r_rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
